irq_concat_sync: RTL and testbench

IRQ_CONCAT_SYNC -- requirements
Module: irq_concat_sync

---
 rtl/irq_concat_sync.sv | 101 ++++++++++
 tb/tb_irq_concat_sync.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/irq_concat_sync.sv
// ----------------------------------------------------------------------------
// irq_concat_sync
//
// Collects SIGNAL_IN_NUM asynchronous interrupt lines into one clock domain.
// Each line is polarity-corrected, synchronised, then qualified either as a
// level (follows the synchronised input) or as a sticky edge (set on a rising
// edge, cleared by a write-1 pulse on clr). The qualified vector is masked by
// en and summarised as irq_any / irq_id (lowest asserted channel).
//
// Parameters
//   SIGNAL_IN_NUM  channel count N, 1..32
//   SYNC_STAGES    synchroniser depth per channel, 1..3
//   EDGE_MASK      bit i = 1 -> channel i is edge mode, 0 -> level mode
//   INV_MASK       bit i = 1 -> channel i input is active-low
//
// Ports
//   clk      single clock for all state
//   rst      asynchronous, active-high reset
//   din      raw interrupt lines, asynchronous to clk
//   en       per-channel output enable (masks dout, never clears pending)
//   clr      per-channel write-1-to-clear for edge channels
//   dout     qualified interrupts, pend & en
//   irq_any  OR of dout
//   irq_id   index of lowest asserted dout bit, 0 when none
// ----------------------------------------------------------------------------
module irq_concat_sync #(
    parameter int                       SIGNAL_IN_NUM = 8,
    parameter int                       SYNC_STAGES   = 2,
    parameter logic [SIGNAL_IN_NUM-1:0] EDGE_MASK     = '0,
    parameter logic [SIGNAL_IN_NUM-1:0] INV_MASK      = '0,
    localparam int                      ID_W          = (SIGNAL_IN_NUM > 1) ? $clog2(SIGNAL_IN_NUM) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SIGNAL_IN_NUM-1:0] din,
    input  logic [SIGNAL_IN_NUM-1:0] en,
    input  logic [SIGNAL_IN_NUM-1:0] clr,
    output logic [SIGNAL_IN_NUM-1:0] dout,
    output logic                     irq_any,
    output logic [ID_W-1:0]          irq_id
);

    // Synchroniser chain holds active-high levels: the inversion is applied
    // before the first flop, so a reset value of 0 always means "inactive"
    // regardless of INV_MASK.
    logic [SYNC_STAGES-1:0][SIGNAL_IN_NUM-1:0] sync;
    logic [SIGNAL_IN_NUM-1:0]                  s;
    logic [SIGNAL_IN_NUM-1:0]                  prev;
    logic [SIGNAL_IN_NUM-1:0]                  pend;
    logic [SIGNAL_IN_NUM-1:0]                  rise;
    logic [SIGNAL_IN_NUM-1:0]                  edge_next;
    logic [SIGNAL_IN_NUM-1:0]                  pend_next;

    assign s = sync[SYNC_STAGES-1];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, giving a true shift chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync[0] <= din ^ INV_MASK;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync[k] <= sync[k-1];
            end
        end
    end

    // Edge channels: a rising edge sets pend and overrides a coincident clear
    // so an interrupt arriving during the acknowledge is never lost.
    // Level channels simply follow s; clr is ignored for them.
    assign rise      = s & ~prev;
    assign edge_next = rise | (pend & ~clr);
    assign pend_next = (EDGE_MASK & edge_next) | (~EDGE_MASK & s);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= '0;
            pend <= '0;
        end else begin
            prev <= s;
            pend <= pend_next;
        end
    end

    assign dout    = pend & en;
    assign irq_any = |dout;

    // Scan from the top down so the lowest asserted index is written last.
    // NOTE: irq_id gets its default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        irq_id = '0;
        for (int i = SIGNAL_IN_NUM - 1; i >= 0; i--) begin
            if (dout[i]) begin
                irq_id = ID_W'(i);
            end
        end
    end

endmodule

// File: tb/tb_irq_concat_sync.sv
// ----------------------------------------------------------------------------
// tb_irq_concat_sync
//
// Directed bench for irq_concat_sync. Two instances share clk/rst:
//   dut_a : defaults (all level, no inversion)
//   dut_b : EDGE_MASK = 0x81 (channels 0 and 7 edge), INV_MASK = 0x02
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_irq_concat_sync;

    logic       clk = 1'b0;
    logic       rst;

    logic [7:0] din_a, en_a, clr_a, dout_a;
    logic       irq_any_a;
    logic [2:0] irq_id_a;

    logic [7:0] din_b, en_b, clr_b, dout_b;
    logic       irq_any_b;
    logic [2:0] irq_id_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    irq_concat_sync dut_a (
        .clk     (clk),
        .rst     (rst),
        .din     (din_a),
        .en      (en_a),
        .clr     (clr_a),
        .dout    (dout_a),
        .irq_any (irq_any_a),
        .irq_id  (irq_id_a)
    );

    irq_concat_sync #(
        .SIGNAL_IN_NUM (8),
        .SYNC_STAGES   (2),
        .EDGE_MASK     (8'h81),
        .INV_MASK      (8'h02)
    ) dut_b (
        .clk     (clk),
        .rst     (rst),
        .din     (din_b),
        .en      (en_b),
        .clr     (clr_b),
        .dout    (dout_b),
        .irq_any (irq_any_b),
        .irq_id  (irq_id_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst   = 1'b1;
        din_a = 8'h00; en_a = 8'hFF; clr_a = 8'h00;
        din_b = 8'h02; en_b = 8'hFF; clr_b = 8'h00;   // ch1 active-low: 1 = idle
        tick(2);

        // Reset state
        check("rst_dout_a",    dout_a,    8'h00);
        check("rst_any_a",     irq_any_a, 1'b0);
        check("rst_id_a",      irq_id_a,  3'd0);
        check("rst_dout_b",    dout_b,    8'h00);

        rst = 1'b0;
        tick(4);
        check("inv_idle_b",    dout_b,    8'h00);

        // Level channels, latency SYNC_STAGES+1 = 3
        din_a = 8'h05;
        tick(2);
        check("lvl_early",     dout_a,    8'h00);
        tick(1);
        check("lvl_set",       dout_a,    8'h05);
        check("lvl_any",       irq_any_a, 1'b1);
        check("lvl_id",        irq_id_a,  3'd0);
        din_a = 8'h00;
        tick(2);
        check("lvl_hold",      dout_a,    8'h05);
        tick(1);
        check("lvl_drop",      dout_a,    8'h00);
        check("lvl_any_drop",  irq_any_a, 1'b0);

        // Priority encoder
        din_a = 8'h30;
        tick(3);
        check("id_4",          irq_id_a,  3'd4);
        en_a = 8'hEF;
        #1;
        check("id_mask_dout",  dout_a,    8'h20);
        check("id_5",          irq_id_a,  3'd5);
        en_a  = 8'hFF;
        din_a = 8'h00;
        tick(3);
        check("id_none",       irq_id_a,  3'd0);
        check("any_none",      irq_any_a, 1'b0);

        // Edge channel 7: 2-cycle pulse is captured and sticky
        din_b = 8'h82;
        tick(2);
        din_b = 8'h02;
        tick(1);
        check("edge_set",      dout_b,    8'h80);
        check("edge_id",       irq_id_b,  3'd7);
        tick(5);
        check("edge_sticky",   dout_b,    8'h80);
        clr_b = 8'h80;
        tick(1);
        clr_b = 8'h00;
        check("edge_clr",      dout_b,    8'h00);

        // Set and clear on the same edge: set wins
        din_b = 8'h82;
        tick(2);
        clr_b = 8'h80;
        tick(1);
        clr_b = 8'h00;
        check("set_wins",      dout_b,    8'h80);
        tick(1);
        check("set_wins_hold", dout_b,    8'h80);
        din_b = 8'h02;
        clr_b = 8'h80;
        tick(1);
        clr_b = 8'h00;
        check("set_wins_clr",  dout_b,    8'h00);

        // Inverted level channel 1
        din_b = 8'h00;
        tick(2);
        check("inv_early",     dout_b,    8'h00);
        tick(1);
        check("inv_set",       dout_b,    8'h02);
        check("inv_id",        irq_id_b,  3'd1);
        en_b = 8'hFD;
        #1;
        check("inv_masked",    dout_b,    8'h00);
        check("inv_masked_any", irq_any_b, 1'b0);
        tick(3);
        en_b = 8'hFF;
        #1;
        check("inv_unmasked",  dout_b,    8'h02);
        din_b = 8'h02;
        tick(3);
        check("inv_release",   dout_b,    8'h00);

        // Edge channel 0 held high across an asynchronous reset pulse
        din_b = 8'h03;
        din_a = 8'h01;
        tick(3);
        check("pre_rst_b",     dout_b,    8'h01);
        check("pre_rst_a",     dout_a,    8'h01);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_b",   dout_b,    8'h00);
        check("async_any_b",   irq_any_b, 1'b0);
        check("async_rst_a",   dout_a,    8'h00);
        tick(1);
        rst = 1'b0;
        tick(2);
        check("post_rst_early", dout_b,   8'h00);
        tick(1);
        check("post_rst_edge", dout_b,    8'h01);
        check("post_rst_lvl",  dout_a,    8'h01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
